// File: rtl/mips_pkg.sv
// Shared defaults and FSM state encoding for the register file scoreboard.
package mips_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_NUM_RD = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending bits, combinational read ports and a sequential flush.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module regfile_scoreboard
    import mips_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = DEFAULT_NUM_RD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     clr_req,
    output logic                     clr_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    rf_state_e          state_q;
    logic [ADDR_W-1:0]  cnt_q;
    logic               busy_q;
    logic [DATA_W-1:0]  regs_q [DEPTH];
    logic [DEPTH-1:0]   pend_q;

    logic idle;
    logic wr_fire_d;
    logic iss_fire_d;

    // clr_req in IDLE takes the cycle; writeback and issue are dropped.
    assign idle       = (state_q == ST_IDLE);
    assign wr_fire_d  = idle && !clr_req && wr_en  && (wr_addr  != '0);
    assign iss_fire_d = idle && !clr_req && iss_en && (iss_addr != '0);
    assign clr_busy   = busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= ADDR_W'(1);
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q == LAST) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Issue is applied after the writeback clear so a same-address pair stays pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            pend_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            regs_q[cnt_q] <= '0;
            pend_q[cnt_q] <= 1'b0;
        end else begin
            if (wr_fire_d) begin
                regs_q[wr_addr] <= wr_data;
                pend_q[wr_addr] <= 1'b0;
            end
            if (iss_fire_d) pend_q[iss_addr] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] data;
        logic              pend;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = regs_q[ra];
            pend = pend_q[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && idle && (ra == wr_addr) && (ra != '0)) begin
                data = wr_data;
                pend = 1'b0;
            end
`endif
            if (!idle || (ra == '0)) begin
                data = '0;
                pend = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
        assign rd_pend[k]                  = pend;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reference model plus literal spot checks.
module tb_regfile_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic                     clk;
    logic                     reset;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pend;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     clr_req;
    logic                     clr_busy;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 0;

    regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .clr_req(clr_req), .clr_busy(clr_busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Model: architectural contents, pending flags, and flush cycles still to run.
    // A flush zeroes everything at once here; partial progress is never visible.
    logic [DATA_W-1:0] m_reg  [DEPTH];
    bit                m_pend [DEPTH];
    int                m_left;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin m_reg[i] <= '0; m_pend[i] <= 0; end
            m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end else if (clr_req) begin
            for (int i = 0; i < DEPTH; i++) begin m_reg[i] <= '0; m_pend[i] <= 0; end
            m_left <= DEPTH - 1;
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_reg[wr_addr] <= wr_data;
                if (!(iss_en && iss_addr == wr_addr)) m_pend[wr_addr] <= 0;
            end
            if (iss_en && iss_addr != 0) m_pend[iss_addr] <= 1;
        end
    end

    function automatic logic [DATA_W-1:0] exp_data(int k);
        int a;
        a = int'(rd_addr[k*ADDR_W +: ADDR_W]);
        if (m_left > 0 || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && a == int'(wr_addr)) return wr_data;
`endif
        return m_reg[a];
    endfunction

    function automatic logic exp_pend(int k);
        int a;
        a = int'(rd_addr[k*ADDR_W +: ADDR_W]);
        if (m_left > 0 || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && a == int'(wr_addr)) return 1'b0;
`endif
        return m_pend[a];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < NUM_RD; k++) begin
                chk($sformatf("model rd_data[%0d]", k), 64'(rd_data[k*DATA_W +: DATA_W]), 64'(exp_data(k)));
                chk($sformatf("model rd_pend[%0d]", k), 64'(rd_pend[k]), 64'(exp_pend(k)));
            end
            chk("model clr_busy", 64'(clr_busy), 64'(m_left > 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wr_en = 0; iss_en = 0; clr_req = 0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
    endtask

    task automatic fill();
        for (int i = 1; i < DEPTH; i++) begin
            wr_en = 1; wr_addr = ADDR_W'(i); wr_data = 32'h1000_0000 + i;
            iss_en = (i % 3 == 0); iss_addr = ADDR_W'(i + 1);
            tick();
        end
        idle_in();
    endtask

    task automatic all_zero(input string nm);
        for (int a = 0; a < DEPTH; a += 2) begin
            set_rd(a, a + 1);
            #1;
            chk({nm, " data0"}, 64'(rd_data[31:0]), 64'h0);
            chk({nm, " data1"}, 64'(rd_data[63:32]), 64'h0);
            chk({nm, " pend"}, 64'(rd_pend), 64'h0);
            tick();
        end
    endtask

    initial begin
        int nbusy;
        reset = 0; rd_addr = '0; wr_addr = '0; wr_data = '0; iss_addr = '0;
        idle_in();
        repeat (3) @(posedge clk);
        #1;
        chk("reset clr_busy", 64'(clr_busy), 64'h0);
        chk("reset rd_data", 64'(rd_data), 64'h0);
        reset = 1;
        chk_on = 1;
        tick();

        // write r5 then read it back
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        tick();
        idle_in(); set_rd(5, 0); #1;
        chk("r5 data", 64'(rd_data[31:0]), 64'hDEADBEEF);
        chk("r5 pend", 64'(rd_pend[0]), 64'h0);
        tick();

        // r0 is hard-wired
        wr_en = 1; wr_addr = 0; wr_data = 32'h1234; iss_en = 1; iss_addr = 0;
        tick();
        idle_in(); set_rd(0, 0); #1;
        chk("r0 data", 64'(rd_data[31:0]), 64'h0);
        chk("r0 pend", 64'(rd_pend[0]), 64'h0);
        tick();

        // issue r7, writeback two cycles later
        iss_en = 1; iss_addr = 7;
        tick();
        idle_in(); set_rd(7, 5); #1;
        chk("r7 pend cyc1", 64'(rd_pend[0]), 64'h1);
        tick();
        chk("r7 pend cyc2", 64'(rd_pend[0]), 64'h1);
        wr_en = 1; wr_addr = 7; wr_data = 32'h55;
`ifndef REGFILE_BYPASS_EN
        #1;
        chk("r7 pend during wb", 64'(rd_pend[0]), 64'h1);
`endif
        tick();
        idle_in(); #1;
        chk("r7 pend after wb", 64'(rd_pend[0]), 64'h0);
        chk("r7 data after wb", 64'(rd_data[31:0]), 64'h55);
        tick();
        iss_en = 1; iss_addr = 7; wr_en = 1; wr_addr = 7; wr_data = 32'h66;
        tick();
        idle_in(); set_rd(5, 7); #1;
        chk("r7 iss+wr pend", 64'(rd_pend[1]), 64'h1);
        chk("r7 iss+wr data", 64'(rd_data[63:32]), 64'h66);
        tick();

        // same-cycle read of a register being written
        wr_en = 1; wr_addr = 3; wr_data = 32'h1111_1111;
        tick();
        wr_data = 32'hA5A5A5A5; set_rd(0, 3); #1;
`ifdef REGFILE_BYPASS_EN
        chk("r3 same-cycle", 64'(rd_data[63:32]), 64'hA5A5A5A5);
`else
        chk("r3 same-cycle", 64'(rd_data[63:32]), 64'h1111_1111);
`endif
        tick();
        idle_in(); #1;
        chk("r3 after edge", 64'(rd_data[63:32]), 64'hA5A5A5A5);
        tick();

        // flush: clr_req wins over a same-cycle write, inputs ignored while busy
        fill();
        set_rd(2, 31); #1;
        chk("fill r31", 64'(rd_data[63:32]), 64'h1000_001F);
        clr_req = 1; wr_en = 1; wr_addr = 2; wr_data = 32'hFFFF;
        tick();
        nbusy = 0;
        for (int i = 0; i < 40 && clr_busy; i++) begin
            nbusy++;
            wr_en = 1; wr_addr = 9; wr_data = 32'hBAD; iss_en = 1; iss_addr = 9;
            clr_req = (i % 2 == 0);
            set_rd(i % DEPTH, 9);
            tick();
        end
        idle_in();
        chk("flush busy cycles", 64'(nbusy), 64'd31);
        all_zero("post-flush");

        // reset mid-flush at cnt=10
        fill();
        clr_req = 1;
        tick();
        clr_req = 0;
        repeat (9) tick();
        chk("busy at cnt10", 64'(clr_busy), 64'h1);
        reset = 0; #1;
        chk("busy on reset", 64'(clr_busy), 64'h0);
        tick();
        reset = 1;
        tick();
        all_zero("post-abort");
        wr_en = 1; wr_addr = 4; wr_data = 32'hCAFE;
        tick();
        idle_in(); set_rd(4, 0); #1;
        chk("r4 after abort", 64'(rd_data[31:0]), 64'hCAFE);
        tick();

        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
